// File: rtl/beam_comb_pkg.sv
// rtl/beam_comb_pkg.sv - Width helpers, saturation and shared constants for beam_combiner.
package beam_comb_pkg;

  localparam int SAT_CNT_W = 16;
  localparam int SAT_MAX_W = 64;

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  function automatic int cmul_w(input int data_w, input int coef_w);
    return prod_w(data_w, coef_w) + 1;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int num_beams);
    return cmul_w(data_w, coef_w) + $clog2(num_beams);
  endfunction

  function automatic int bidx_w(input int num_beams);
    return (num_beams > 1) ? $clog2(num_beams) : 1;
  endfunction

  // Clamp a sign-extended accumulator value into the signed data_w range.
  function automatic logic signed [SAT_MAX_W-1:0] saturate(input logic signed [SAT_MAX_W-1:0] v,
                                                           input int data_w);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/beam_cmul.sv
// rtl/beam_cmul.sv - Registered conjugate complex multiply: (i*cos + q*sin, q*cos - i*sin).
module beam_cmul
  import beam_comb_pkg::*;
#(
  parameter int DATA_W = 15,
  parameter int COEF_W = 5,
  parameter int CMUL_W = cmul_w(DATA_W, COEF_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic                     first_i,
  input  logic                     last_i,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] q_i,
  input  logic signed [COEF_W-1:0] cos_i,
  input  logic signed [COEF_W-1:0] sin_i,
  output logic                     valid_o,
  output logic                     first_o,
  output logic                     last_o,
  output logic signed [CMUL_W-1:0] re_o,
  output logic signed [CMUL_W-1:0] im_o
);

  localparam int PROD_W = prod_w(DATA_W, COEF_W);

  logic signed [PROD_W-1:0] i_cos, q_sin, q_cos, i_sin;
  logic signed [CMUL_W-1:0] re_d, im_d, re_q, im_q;
  logic                     valid_q, first_q, last_q;

  always_comb begin
    i_cos = PROD_W'(i_i) * PROD_W'(cos_i);
    q_sin = PROD_W'(q_i) * PROD_W'(sin_i);
    q_cos = PROD_W'(q_i) * PROD_W'(cos_i);
    i_sin = PROD_W'(i_i) * PROD_W'(sin_i);
    re_d  = CMUL_W'(i_cos) + CMUL_W'(q_sin);
    im_d  = CMUL_W'(q_cos) - CMUL_W'(i_sin);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      valid_q <= valid_i;
      first_q <= first_i;
      last_q  <= last_i;
      if (valid_i) begin
        re_q <= re_d;
        im_q <= im_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign re_o    = re_q;
  assign im_o    = im_q;

endmodule

// File: rtl/beam_combiner.sv
// rtl/beam_combiner.sv - Time-multiplexed weighted beam combiner with double-buffered weights.
// Optional saturation event counter enabled by BEAM_COMB_SAT_CNT_EN.
module beam_combiner
  import beam_comb_pkg::*;
#(
  parameter  int NUM_BEAMS = 2,
  parameter  int DATA_W    = 15,
  parameter  int COEF_W    = 5,
  localparam int BIDX_W    = bidx_w(NUM_BEAMS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     coef_we,
  input  logic [BIDX_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_cos,
  input  logic signed [COEF_W-1:0] coef_sin,
  input  logic                     coef_commit,
  output logic                     commit_pending,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_i,
  output logic signed [DATA_W-1:0] out_q,
  output logic                     frame_err,
  output logic [SAT_CNT_W-1:0]     sat_cnt
);

  localparam int                CMUL_W    = cmul_w(DATA_W, COEF_W);
  localparam int                ACC_W     = acc_w(DATA_W, COEF_W, NUM_BEAMS);
  localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(NUM_BEAMS - 1);

  logic [BIDX_W-1:0]        bidx_q, bidx_d, cur_bidx;
  logic                     pending_q, pending_d, copy;
  logic                     frame_err_q, frame_err_d;
  logic signed [COEF_W-1:0] sh_cos_q  [NUM_BEAMS];
  logic signed [COEF_W-1:0] sh_sin_q  [NUM_BEAMS];
  logic signed [COEF_W-1:0] act_cos_q [NUM_BEAMS];
  logic signed [COEF_W-1:0] act_sin_q [NUM_BEAMS];
  logic signed [COEF_W-1:0] w_cos, w_sin;

  // A beam-0 sample that triggers the bank copy reads the shadow bank directly.
  always_comb begin
    cur_bidx    = in_first ? '0 : bidx_q;
    bidx_d      = bidx_q;
    if (in_valid) bidx_d = (cur_bidx == LAST_BIDX) ? '0 : cur_bidx + BIDX_W'(1);
    copy        = in_valid && (cur_bidx == '0) && pending_q;
    pending_d   = coef_commit || (pending_q && !copy);
    frame_err_d = in_valid && in_first && (bidx_q != '0);
    w_cos       = copy ? sh_cos_q[0] : act_cos_q[cur_bidx];
    w_sin       = copy ? sh_sin_q[0] : act_sin_q[cur_bidx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BEAMS; b++) begin
        sh_cos_q[b]  <= '0;
        sh_sin_q[b]  <= '0;
        act_cos_q[b] <= '0;
        act_sin_q[b] <= '0;
      end
    end else begin
      if (coef_we) begin
        sh_cos_q[coef_addr] <= coef_cos;
        sh_sin_q[coef_addr] <= coef_sin;
      end
      if (copy) begin
        for (int b = 0; b < NUM_BEAMS; b++) begin
          act_cos_q[b] <= sh_cos_q[b];
          act_sin_q[b] <= sh_sin_q[b];
        end
      end
    end
  end

  logic                     p_valid, p_first, p_last;
  logic signed [CMUL_W-1:0] p_re, p_im;

  beam_cmul #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .CMUL_W (CMUL_W)
  ) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (in_valid),
    .first_i (cur_bidx == '0),
    .last_i  (cur_bidx == LAST_BIDX),
    .i_i     (in_i),
    .q_i     (in_q),
    .cos_i   (w_cos),
    .sin_i   (w_sin),
    .valid_o (p_valid),
    .first_o (p_first),
    .last_o  (p_last),
    .re_o    (p_re),
    .im_o    (p_im)
  );

  logic signed [ACC_W-1:0]     acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                        done_q, done_d;
  logic signed [SAT_MAX_W-1:0] ext_re, ext_im;
  logic signed [DATA_W-1:0]    out_i_q, out_i_d, out_q_q, out_q_d;
  logic                        out_valid_q;

  // A beam-0 product reloads the sum, which also drops any truncated partial frame.
  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    done_d   = p_valid && p_last;
    if (p_valid) begin
      if (p_first) begin
        acc_re_d = ACC_W'(p_re);
        acc_im_d = ACC_W'(p_im);
      end else begin
        acc_re_d = acc_re_q + ACC_W'(p_re);
        acc_im_d = acc_im_q + ACC_W'(p_im);
      end
    end
    ext_re  = SAT_MAX_W'(acc_re_q);
    ext_im  = SAT_MAX_W'(acc_im_q);
    out_i_d = done_q ? DATA_W'(saturate(ext_re, DATA_W)) : out_i_q;
    out_q_d = done_q ? DATA_W'(saturate(ext_im, DATA_W)) : out_q_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bidx_q      <= '0;
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      bidx_q      <= bidx_d;
      pending_q   <= pending_d;
      frame_err_q <= frame_err_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      done_q      <= done_d;
      out_valid_q <= done_q;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

`ifdef BEAM_COMB_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic                 clamp;

  always_comb begin
    clamp     = (saturate(ext_re, DATA_W) != ext_re) || (saturate(ext_im, DATA_W) != ext_im);
    sat_cnt_d = sat_cnt_q;
    if (done_q && clamp && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;
`endif

  assign commit_pending = pending_q;
  assign out_valid      = out_valid_q;
  assign out_i          = out_i_q;
  assign out_q          = out_q_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_beam_combiner.sv
// tb/tb_beam_combiner.sv - Scoreboard bench for beam_combiner with directed frames.
module tb_beam_combiner;

  localparam int DATA_W = 15;
  localparam int COEF_W = 5;
`ifdef BEAM_COMB_SAT_CNT_EN
  localparam int SAT_ON = 1;
`else
  localparam int SAT_ON = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_first = 1'b0;
  logic signed [DATA_W-1:0] in_i = '0;
  logic signed [DATA_W-1:0] in_q = '0;
  logic                     coef_we = 1'b0;
  logic [0:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_cos = '0;
  logic signed [COEF_W-1:0] coef_sin = '0;
  logic                     coef_commit = 1'b0;
  logic                     commit_pending;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic                     frame_err;
  logic [15:0]              sat_cnt;

  beam_combiner dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_first       (in_first),
    .in_i           (in_i),
    .in_q           (in_q),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_cos       (coef_cos),
    .coef_sin       (coef_sin),
    .coef_commit    (coef_commit),
    .commit_pending (commit_pending),
    .out_valid      (out_valid),
    .out_i          (out_i),
    .out_q          (out_q),
    .frame_err      (frame_err),
    .sat_cnt        (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ei;
    int eq;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   fe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_i", longint'(out_i), longint'(e.ei));
        chk("out_q", longint'(out_q), longint'(e.eq));
        chk("out_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input int a, input int c, input int s);
    coef_we = 1'b1;
    coef_addr = 1'(a);
    coef_cos = COEF_W'(c);
    coef_sin = COEF_W'(s);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
  endtask

  task automatic beat(input bit first, input int i, input int q, input bit push, input int ei, input int eq);
    in_valid = 1'b1;
    in_first = first;
    in_i = DATA_W'(i);
    in_q = DATA_W'(q);
    if (push) exp_q.push_back('{ei, eq, cyc + 3});
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    coef_we = 1'b0;
    coef_commit = 1'b0;
  endtask

  initial begin
    int i0, q0, i1, q1;
    int waited;

    idle(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // Basic combine
    wr(0, 8, 0);
    wr(1, 0, 4);
    commit();
    chk("basic_pending_set", commit_pending, 1);
    beat(1, 100, 0, 0, 0, 0);
    chk("basic_pending_clr", commit_pending, 0);
    beat(0, 0, 50, 1, 1000, 0);
    idle(5);

    // Saturation
    wr(0, 15, 0);
    wr(1, 15, 0);
    commit();
    beat(1, 16383, 0, 0, 0, 0);
    beat(0, 16383, 0, 1, 16383, 0);
    beat(1, -16384, 0, 0, 0, 0);
    beat(0, -16384, 0, 1, -16384, 0);
    idle(5);
    chk("sat_cnt", sat_cnt, 2 * SAT_ON);

    // Atomic commit
    beat(1, 10, 20, 0, 0, 0);
    coef_we = 1'b1; coef_addr = 1'b0; coef_cos = 5'sd2; coef_sin = 5'sd1; coef_commit = 1'b1;
    beat(0, 4, -3, 1, 210, 255);
    chk("atomic_pending_set", commit_pending, 1);
    coef_we = 1'b1; coef_addr = 1'b1; coef_cos = -5'sd3; coef_sin = 5'sd6;
    beat(1, 7, 5, 0, 0, 0);
    chk("atomic_pending_clr", commit_pending, 0);
    beat(0, 1, 2, 1, 34, 33);
    beat(1, 1, 1, 0, 0, 0);
    beat(0, 1, 1, 1, 18, 16);
    commit();
    beat(1, 1, 1, 0, 0, 0);
    beat(0, 1, 1, 1, 6, -8);
    idle(5);

    // Framing error, with an idle gap inside the restarted frame
    beat(1, 5, 5, 0, 0, 0);
    beat(1, 9, 9, 0, 0, 0);
    chk("frame_err_pulse", frame_err, 1);
    tick();
    chk("frame_err_clear", frame_err, 0);
    beat(0, 2, 0, 1, 21, -3);
    idle(5);

    // Back-to-back frames
    wr(0, 8, 0);
    wr(1, 0, 4);
    commit();
    for (int k = 0; k < 8; k++) begin
      i0 = 37 * k - 100;
      q0 = 200 - 11 * k;
      i1 = 5 * k + 3;
      q1 = -13 * k;
      beat(1, i0, q0, 0, 0, 0);
      beat(0, i1, q1, 1, 8 * i0 + 4 * q1, 8 * q0 - 4 * i1);
    end
    idle(6);
    chk("sat_cnt_final", sat_cnt, 2 * SAT_ON);

    // Reset mid-frame with a commit pending
    wr(0, 5, 5);
    coef_commit = 1'b1;
    beat(1, 100, 100, 0, 0, 0);
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_out_i", out_i, 0);
    chk("mid_rst_out_q", out_q, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pending", commit_pending, 0);
    chk("mid_rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    idle(4);
    beat(1, 50, 60, 0, 0, 0);
    beat(0, 70, 80, 1, 0, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      tick();
      waited++;
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frame_err_count", fe_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beam_combiner.md
# beam_combiner

Time-multiplexed, parametrised successor of the two-beam phase-shift combiner. It accepts one complex sample per beam per frame on a single streaming input and applies a per-beam conjugate complex weight, (i·cos + q·sin, q·cos − i·sin). It accumulates the weighted beams across the frame and emits one saturated complex sum per frame. Weights are written through a double-buffered coefficient bank that is applied atomically at a frame boundary. The block sits between the per-channel I/Q front end and the delta-sigma modulator input.

## Interface
- NUM_BEAMS, 2, beams per frame (≥1)
- DATA_W, 15, signed I/Q sample and output width
- COEF_W, 5, signed cos/sin weight width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  sample strobe; no backpressure
- in_first  in  1  marks beam-0 sample; qualified by in_valid
- in_i, in_q  in  DATA_W  signed sample
- coef_we  in  1  shadow-bank write strobe
- coef_addr  in  BIDX_W  beam index, BIDX_W = max(1, clog2(NUM_BEAMS))
- coef_cos, coef_sin  in  COEF_W  signed weights
- coef_commit  in  1  request shadow→active copy
- commit_pending  out  1  commit requested, not yet applied
- out_valid  out  1  one-cycle result strobe
- out_i, out_q  out  DATA_W  saturated frame sum
- frame_err  out  1  one-cycle pulse on a truncated frame
- sat_cnt  out  16  saturation event counter (see Configuration)

## Operation
- Beam counter bidx:
  - Increments on each accepted sample (in_valid=1).
  - Wraps NUM_BEAMS−1→0.
  - An accepted sample with in_first=1 forces bidx=0 for that sample.
- Truncated frame:
  - Condition: in_first=1 while the running bidx≠0.
  - Discards the partial accumulation; no out_valid for that frame.
  - Pulses frame_err one cycle later.
  - The new sample starts a fresh frame.
- Product stage:
  - PROD_W = DATA_W+COEF_W. CMUL_W = PROD_W+1. ACC_W = CMUL_W+clog2(NUM_BEAMS).
  - All arithmetic is signed with full-precision sign extension; no internal overflow.
- Accumulator:
  - A beam-0 sample loads its cmul result.
  - Other beams add to the running sum.
  - The last beam (bidx=NUM_BEAMS−1) hands the sum to the output stage.
- Saturation:
  - Values > 2^(DATA_W−1)−1 clamp to 2^(DATA_W−1)−1.
  - Values < −2^(DATA_W−1) clamp to −2^(DATA_W−1).
  - Otherwise the output is the low DATA_W bits.
- Coefficient banks:
  - coef_we writes shadow[coef_addr] at the clock edge.
  - coef_commit sets pending.
  - When a beam-0 sample is accepted with pending=1, that sample and the whole frame use the shadow contents, active←shadow at that edge, and pending clears.
  - A write in the copy cycle is not part of the copy: the copy takes the pre-write shadow value.
  - A commit in the same cycle as a copy re-arms pending.
  - With NUM_BEAMS=1, every sample is beam 0.

## Timing
- Sample accepted in cycle T → products registered T+1 → accumulator T+2 → out_valid/out_i/out_q in cycle T+3 (sample T = last beam).
- Full throughput: in_valid every cycle yields one out_valid per NUM_BEAMS cycles.
- out_i/out_q hold their value between strobes.
- Reset values:
  - All outputs 0.
  - bidx=0, accumulator 0, pending 0.
  - Both banks all-zero.
  - sat_cnt 0.
- Reset mid-frame discards all in-flight data; no out_valid is produced for it.
- in_valid=0 gaps inside a frame are allowed; the frame completes on its last beam.

## Configuration
- BEAM_COMB_SAT_CNT_EN defined:
  - sat_cnt increments once per out_valid in which out_i or out_q clamped.
  - Saturates at 0xFFFF.
- Undefined: sat_cnt is tied to 0 and the counter logic is absent. The port list is unchanged.

## Structure
- Package beam_comb_pkg holds:
  - width functions prod_w/cmul_w/acc_w/bidx_w
  - the saturate function (ACC_W→DATA_W)
  - the SAT_CNT_W=16 constant
- Sub-module beam_cmul: registered conjugate complex multiply (stage 1). beam_combiner owns the counter, banks, accumulator and saturation.

## Test plan
- Basic combine: defaults, shadow {b0: cos=8,sin=0; b1: cos=0,sin=4}, commit; frame b0 (100,0), b1 (0,50) -> out (1000,0) in cycle T+3 after b1.
- Positive saturation: both beams (16383,0), cos=15, sin=0 -> out_i=16383 (0x3FFF), sat_cnt=1 with macro and 0 without. Negative saturation: both beams (−16384,0) -> out_i=−16384 (0x4000).
- Atomic commit: commit mid-frame, then write b1 in the same cycle as the next beam-0 acceptance -> current frame uses old weights, next frame new b0 and old b1, commit_pending drops at beam-0 acceptance.
- Framing error: samples b0 then in_first=1 -> frame_err pulse, no out_valid; following b1 completes a new frame correctly.
- Back-to-back: 8 frames, in_valid every cycle -> out_valid every 2nd cycle, values match the reference model.
- Reset mid-frame: rst_n=0 after b0 -> no out_valid; all outputs 0; weights zero, so the next frame gives (0,0).
